// File: rtl/keypad_pkg.sv
// ----------------------------------------------------------------------------
// keypad_pkg
// Shared types and constants for the 4x4 hex keypad encoder:
//   state_t    - scan/debounce FSM states
//   KEYMAP     - key code lookup, indexed by {row, col}
//   COL_RESET  - column drive pattern after reset (column 0 low)
//   one_low    - true when exactly one bit of an active-low nibble is low
//   low_index  - index of the low bit of a one-low nibble
// ----------------------------------------------------------------------------
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        PRESSED,
        HELD
    } state_t;

    // Row-major physical layout:
    //   row 0: 1 2 3 A
    //   row 1: 4 5 6 B
    //   row 2: 7 8 9 C
    //   row 3: E 0 F D
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    localparam logic [3:0] COL_RESET = 4'b1110;

    function automatic logic one_low(input logic [3:0] v);
        return (v == 4'b1110) || (v == 4'b1101) ||
               (v == 4'b1011) || (v == 4'b0111);
    endfunction

    // Only meaningful when one_low(v) holds; other patterns map to 0.
    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// ----------------------------------------------------------------------------
// keypad_row_sync
// Two-flop synchronizer for the asynchronous, active-low keypad rows.
// Resets to all-ones so that "no key pressed" is seen while in reset.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous, active-high
//   d      in   [3:0] raw row inputs
//   q      out  [3:0] synchronized rows
// ----------------------------------------------------------------------------
module keypad_row_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and simulation matches the synthesized netlist.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 4'b1111;
            q    <= 4'b1111;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_hex_encoder.sv
// ----------------------------------------------------------------------------
// keypad_hex_encoder
// Scans a 4x4 hex keypad one column at a time, debounces press and release,
// and encodes each accepted press to a 4-bit code with a one-cycle strobe.
// Successive codes are loaded alternately into operand registers A and B.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous, active-high
//   row_in     in   [3:0] keypad rows, active-low, asynchronous
//   col_out    out  [3:0] column drive, active-low, exactly one bit low
//   key_code   out  [3:0] code of the last accepted key
//   key_valid  out  one-cycle pulse per accepted press
//   a_out      out  [3:0] operand A
//   b_out      out  [3:0] operand B
//   load_b     out  0: next press loads A, 1: next press loads B
// ----------------------------------------------------------------------------
module keypad_hex_encoder
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [3:0] a_out,
    output logic [3:0] b_out,
    output logic       load_b
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [CNT_W-1:0]   cnt;       // match count in DEBOUNCE, release count in HELD
    logic [3:0]         row_s;
    logic [3:0]         row_lat;
    logic               tick;
    logic               accept;
    logic [3:0]         key_new;
    logic [3:0]         col_next;

    keypad_row_sync u_row_sync (
        .clk   (clk),
        .reset (reset),
        .d     (row_in),
        .q     (row_s)
    );

    // accept marks the tick on which the last required matching sample is
    // seen; the press is committed on that edge so key_valid rises in the
    // very next cycle, which is also the single PRESSED cycle.
    // NOTE: every always_comb output is given a default before any branch,
    // otherwise an unassigned path infers a latch.
    always_comb begin
        tick     = (div_cnt == DIV_W'(SCAN_DIV - 1));
        key_new  = KEYMAP[{low_index(row_s), low_index(col_out)}];
        col_next = {col_out[2:0], col_out[3]};
        accept   = 1'b0;
        if (tick) begin
            case (state)
                SCAN:     accept = one_low(row_s) && (DEBOUNCE_SCANS == 1);
                DEBOUNCE: accept = (row_s == row_lat) &&
                                   (cnt == CNT_W'(DEBOUNCE_SCANS - 1));
                default:  accept = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCAN;
            div_cnt   <= '0;
            cnt       <= '0;
            row_lat   <= 4'b1111;
            col_out   <= COL_RESET;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            a_out     <= 4'h0;
            b_out     <= 4'h0;
            load_b    <= 1'b0;
        end else begin
            key_valid <= 1'b0;

            // The column only ever changes on a tick, where the divider wraps
            // anyway, so each new column always gets a full dwell.
            if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end

            if (accept) begin
                key_valid <= 1'b1;
                key_code  <= key_new;
                if (load_b) begin
                    b_out <= key_new;
                end else begin
                    a_out <= key_new;
                end
                load_b <= ~load_b;
            end

            case (state)
                SCAN: begin
                    if (tick) begin
                        if (one_low(row_s)) begin
                            row_lat <= row_s;
                            cnt     <= CNT_W'(1);
                            state   <= accept ? PRESSED : DEBOUNCE;
                        end else begin
                            // Idle or multi-key (ghosting): keep scanning.
                            col_out <= col_next;
                        end
                    end
                end

                DEBOUNCE: begin
                    if (tick) begin
                        if (row_s == row_lat) begin
                            if (accept) begin
                                state <= PRESSED;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt     <= '0;
                            col_out <= col_next;
                            state   <= SCAN;
                        end
                    end
                end

                PRESSED: begin
                    cnt   <= '0;
                    state <= HELD;
                end

                HELD: begin
                    if (tick) begin
                        if (row_s == 4'b1111) begin
                            if (cnt == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                                cnt     <= '0;
                                col_out <= col_next;
                                state   <= SCAN;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_hex_encoder.sv
// ----------------------------------------------------------------------------
// tb_keypad_hex_encoder
// Directed bench for keypad_hex_encoder with SCAN_DIV = 4, DEBOUNCE_SCANS = 3.
// The keypad is modelled as a 16-bit mask of pressed keys: a row reads low
// whenever col_out drives the column of a pressed key in that row.
// Key index = row*4 + col.
// ----------------------------------------------------------------------------
module tb_keypad_hex_encoder;

    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic [3:0]  a_out;
    logic [3:0]  b_out;
    logic        load_b;

    logic [15:0] keys = '0;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_cnt    = 0;
    int double_cnt   = 0;
    logic prev_valid = 1'b0;

    keypad_hex_encoder #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_out   (col_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .a_out     (a_out),
        .b_out     (b_out),
        .load_b    (load_b)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !col_out[c]) begin
                    row_in[r] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (key_valid) pulse_cnt++;
        if (key_valid && prev_valid) double_cnt++;
        prev_valid = key_valid;
    end

    task automatic wait_col(input logic [3:0] target, output bit found);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (col_out === target) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_press(input int idx, output int pulses);
        int start;
        start = pulse_cnt;
        keys[idx] = 1'b1;
        repeat (40) @(negedge clk);
        keys = '0;
        repeat (60) @(negedge clk);
        pulses = pulse_cnt - start;
    endtask

    task automatic check_reset_values(input string tag);
        tests_run++;
        if (col_out !== 4'b1110) begin
            tests_failed++;
            $display("FAIL %s_col: got %b, expected 1110", tag, col_out);
        end
        tests_run++;
        if (key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_valid: got %b, expected 0", tag, key_valid);
        end
        tests_run++;
        if (a_out !== 4'h0) begin
            tests_failed++;
            $display("FAIL %s_a: got %h, expected 0", tag, a_out);
        end
        tests_run++;
        if (b_out !== 4'h0) begin
            tests_failed++;
            $display("FAIL %s_b: got %h, expected 0", tag, b_out);
        end
        tests_run++;
        if (load_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s_load_b: got %b, expected 0", tag, load_b);
        end
        tests_run++;
        if (key_code !== 4'h0) begin
            tests_failed++;
            $display("FAIL %s_code: got %h, expected 0", tag, key_code);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        keys  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset");
        // Ticks at the 4th and 8th edges after release: 1110 -> 1101 -> 1011.
        repeat (10) @(negedge clk);
        tests_run++;
        if (col_out !== 4'b1011) begin
            tests_failed++;
            $display("FAIL scan_rotation: got %b, expected 1011", col_out);
        end
        // Asynchronous reset between clock edges.
        #1 reset = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single_press();
        bit found;
        int start;
        int first_valid;
        int col_bad;
        start       = pulse_cnt;
        first_valid = -1;
        col_bad     = 0;
        wait_col(4'b1101, found);
        keys[6] = 1'b1;                       // '6' = row 1, col 2
        wait_col(4'b1011, found);
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL press6_reach_col: got %b, expected 1011", col_out);
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (col_out !== 4'b1011) col_bad++;
            if (key_valid === 1'b1 && first_valid < 0) first_valid = i;
        end
        keys = '0;
        // Samples at +4, +8, +12 cycles after the column change.
        tests_run++;
        if (first_valid != 12) begin
            tests_failed++;
            $display("FAIL press6_latency: got %0d, expected 12", first_valid);
        end
        // Release seen from the tick at +44; third release tick is +52.
        for (int j = 1; j <= 11; j++) begin
            @(negedge clk);
            if (col_out !== 4'b1011) col_bad++;
        end
        tests_run++;
        if (col_bad != 0) begin
            tests_failed++;
            $display("FAIL press6_col_held: got %0d bad cycles, expected 0", col_bad);
        end
        @(negedge clk);
        tests_run++;
        if (col_out !== 4'b0111) begin
            tests_failed++;
            $display("FAIL press6_rescan: got %b, expected 0111", col_out);
        end
        tests_run++;
        if (pulse_cnt - start != 1) begin
            tests_failed++;
            $display("FAIL press6_pulses: got %0d, expected 1", pulse_cnt - start);
        end
        tests_run++;
        if (key_code !== 4'h6) begin
            tests_failed++;
            $display("FAIL press6_code: got %h, expected 6", key_code);
        end
        tests_run++;
        if (a_out !== 4'h6 || b_out !== 4'h0) begin
            tests_failed++;
            $display("FAIL press6_ab: got a=%h b=%h, expected a=6 b=0", a_out, b_out);
        end
        tests_run++;
        if (load_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL press6_load_b: got %b, expected 1", load_b);
        end
    endtask

    task automatic test_second_press();
        int pulses;
        do_press(7, pulses);                  // 'B' = row 1, col 3
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL pressB_pulses: got %0d, expected 1", pulses);
        end
        tests_run++;
        if (key_code !== 4'hB) begin
            tests_failed++;
            $display("FAIL pressB_code: got %h, expected b", key_code);
        end
        tests_run++;
        if (a_out !== 4'h6 || b_out !== 4'hB) begin
            tests_failed++;
            $display("FAIL pressB_ab: got a=%h b=%h, expected a=6 b=b", a_out, b_out);
        end
        tests_run++;
        if (load_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL pressB_load_b: got %b, expected 0", load_b);
        end

        do_press(13, pulses);                 // '0' = row 3, col 1
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("FAIL press0_pulses: got %0d, expected 1", pulses);
        end
        tests_run++;
        if (key_code !== 4'h0 || a_out !== 4'h0 || b_out !== 4'hB) begin
            tests_failed++;
            $display("FAIL press0_regs: got code=%h a=%h b=%h, expected code=0 a=0 b=b",
                     key_code, a_out, b_out);
        end
        tests_run++;
        if (load_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL press0_load_b: got %b, expected 1", load_b);
        end
    endtask

    task automatic test_bounce();
        bit found;
        int start;
        start = pulse_cnt;
        wait_col(4'b1101, found);
        keys[10] = 1'b1;                      // '9' = row 2, col 2
        wait_col(4'b1011, found);
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL bounce_reach_col: got %b, expected 1011", col_out);
        end
        // Held through the ticks at +4 and +8 only.
        repeat (8) @(negedge clk);
        keys = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (col_out !== 4'b1011) begin
            tests_failed++;
            $display("FAIL bounce_col_held: got %b, expected 1011", col_out);
        end
        @(negedge clk);
        tests_run++;
        if (col_out !== 4'b0111) begin
            tests_failed++;
            $display("FAIL bounce_rescan: got %b, expected 0111", col_out);
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (pulse_cnt - start != 0) begin
            tests_failed++;
            $display("FAIL bounce_pulses: got %0d, expected 0", pulse_cnt - start);
        end
        tests_run++;
        if (a_out !== 4'h0 || b_out !== 4'hB || load_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL bounce_regs: got a=%h b=%h load_b=%b, expected a=0 b=b load_b=1",
                     a_out, b_out, load_b);
        end
    endtask

    task automatic test_multi_key();
        bit found;
        int start;
        int bad;
        logic [3:0] seen;
        start = pulse_cnt;
        bad   = 0;
        seen  = 4'b0000;
        wait_col(4'b1101, found);
        keys[0] = 1'b1;                       // '1' = row 0, col 0
        keys[8] = 1'b1;                       // '7' = row 2, col 0
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            seen = seen | ~col_out;
            if ($countones(~col_out) != 1) bad++;
        end
        keys = '0;
        repeat (20) @(negedge clk);
        tests_run++;
        if (pulse_cnt - start != 0) begin
            tests_failed++;
            $display("FAIL multikey_pulses: got %0d, expected 0", pulse_cnt - start);
        end
        tests_run++;
        if (seen !== 4'b1111) begin
            tests_failed++;
            $display("FAIL multikey_rotation: got columns %b, expected 1111", seen);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL multikey_onehot: got %0d bad cycles, expected 0", bad);
        end
    endtask

    task automatic test_reset_mid_hold();
        bit found;
        int start;
        found = 1'b0;
        keys[2] = 1'b1;                       // '3' = row 0, col 2
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!found) begin
            tests_failed++;
            $display("FAIL hold3_valid: got no key_valid, expected one within 100 cycles");
        end
        repeat (10) @(negedge clk);
        tests_run++;
        if (b_out !== 4'h3 || load_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold3_b: got b=%h load_b=%b, expected b=3 load_b=0", b_out, load_b);
        end
        #1 reset = 1'b1;
        #1;
        check_reset_values("hold_reset");
        repeat (2) @(negedge clk);
        start = pulse_cnt;
        reset = 1'b0;
        repeat (60) @(negedge clk);
        keys = '0;
        repeat (40) @(negedge clk);
        tests_run++;
        if (pulse_cnt - start != 1) begin
            tests_failed++;
            $display("FAIL after_reset_pulses: got %0d, expected 1", pulse_cnt - start);
        end
        tests_run++;
        if (key_code !== 4'h3 || a_out !== 4'h3 || b_out !== 4'h0) begin
            tests_failed++;
            $display("FAIL after_reset_regs: got code=%h a=%h b=%h, expected code=3 a=3 b=0",
                     key_code, a_out, b_out);
        end
        tests_run++;
        if (load_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_reset_load_b: got %b, expected 1", load_b);
        end
    endtask

    task automatic test_back_to_back();
        tests_run++;
        if (double_cnt != 0) begin
            tests_failed++;
            $display("FAIL valid_back_to_back: got %0d double-high cycles, expected 0",
                     double_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_second_press();
        test_bounce();
        test_multi_key();
        test_reset_mid_hold();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
